// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for a 5-stage pipeline: stall/flush generation,
// halt with dcache writeback handshake, and saturating stall/flush cycle counters.
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_rt,
  input  logic             exm_dREN,
  input  logic             exm_dWEN,
  input  logic             exm_branch_taken,
  input  logic             id_jump,
  input  logic             mwb_halt,
  input  logic             flush_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exm_en,
  output logic             mwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exm_flush,
  output logic             dcache_flush_req,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t state;
  logic   mem_wait;
  logic   load_use;
  logic   any_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign mem_wait = (exm_dREN | exm_dWEN) & ~dhit;
  // Only loads whose result is not yet available; r0 never creates a dependency.
  assign load_use = idex_dREN & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exm_en     = 1'b0;
    mwb_en     = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exm_flush  = 1'b0;
    if (nRST && state == RUN && !mem_wait) begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      idex_en = 1'b1;
      exm_en  = 1'b1;
      mwb_en  = 1'b1;
      if (exm_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exm_flush  = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, drop a bubble into ID/EX (needs its enable to clear).
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  assign any_flush = ifid_flush | idex_flush | exm_flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state            <= RUN;
      halt             <= 1'b0;
      dcache_flush_req <= 1'b0;
      stall_cnt        <= '0;
      flush_cnt        <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!pc_en)    stall_cnt <= sat_inc(stall_cnt);
          if (any_flush) flush_cnt <= sat_inc(flush_cnt);
          if (mwb_halt) begin
            state            <= FLUSH;
            dcache_flush_req <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_done) begin
            state            <= HALTED;
            dcache_flush_req <= 1'b0;
            halt             <= 1'b1;
          end
        end
        HALTED: begin
          halt             <= 1'b1;
          dcache_flush_req <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized traffic checked
// against a rule-level reference model (priority table, state number, counters).
module tb_hazard_controller;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, ifid_uses_rt, idex_dREN, exm_dREN, exm_dWEN;
  logic        exm_branch_taken, id_jump, mwb_halt, flush_done;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;

  logic        pc_en, ifid_en, idex_en, exm_en, mwb_en;
  logic        ifid_flush, idex_flush, exm_flush, dcache_flush_req, halt;
  logic [15:0] stall_cnt, flush_cnt;

  logic        pc_en2, ifid_en2, idex_en2, exm_en2, mwb_en2;
  logic        ifid_flush2, idex_flush2, exm_flush2, dcache_flush_req2, halt2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  logic [7:0]  outs, outs2;
  logic [37:0] regs;

  assign outs  = {pc_en, ifid_en, idex_en, exm_en, mwb_en, ifid_flush, idex_flush, exm_flush};
  assign outs2 = {pc_en2, ifid_en2, idex_en2, exm_en2, mwb_en2, ifid_flush2, idex_flush2, exm_flush2};
  assign regs  = {stall_cnt, flush_cnt, stall_cnt2, flush_cnt2, halt, dcache_flush_req};

  int tests  = 0;
  int failed = 0;

  // Reference model: 0=running, 1=writing back dcache, 2=halted
  int m_state;
  int m_stall, m_flush, m_stall2, m_flush2;

  always #5 CLK = ~CLK;

  hazard_controller #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .exm_dREN(exm_dREN), .exm_dWEN(exm_dWEN),
    .exm_branch_taken(exm_branch_taken), .id_jump(id_jump), .mwb_halt(mwb_halt),
    .flush_done(flush_done), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exm_en(exm_en), .mwb_en(mwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exm_flush(exm_flush), .dcache_flush_req(dcache_flush_req), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_controller #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .exm_dREN(exm_dREN), .exm_dWEN(exm_dWEN),
    .exm_branch_taken(exm_branch_taken), .id_jump(id_jump), .mwb_halt(mwb_halt),
    .flush_done(flush_done), .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2),
    .exm_en(exm_en2), .mwb_en(mwb_en2), .ifid_flush(ifid_flush2), .idex_flush(idex_flush2),
    .exm_flush(exm_flush2), .dcache_flush_req(dcache_flush_req2), .halt(halt2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  // Expected {pc, ifid_en, idex_en, exm_en, mwb_en, ifid_fl, idex_fl, exm_fl}
  function automatic logic [7:0] model_outs();
    logic lu;
    if (!nRST || m_state != 0) return 8'h00;
    if ((exm_dREN || exm_dWEN) && !dhit) return 8'h00;
    if (exm_branch_taken) return 8'b11111_111;
    lu = idex_dREN && idex_rt != 0 &&
         (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    if (lu) return 8'b00111_010;
    if (id_jump) return 8'b11111_100;
    if (!ihit) return 8'b01111_100;
    return 8'b11111_000;
  endfunction

  function automatic logic [37:0] model_regs();
    logic [15:0] s, f;
    logic [1:0]  s2, f2;
    s = m_stall[15:0]; f = m_flush[15:0]; s2 = m_stall2[1:0]; f2 = m_flush2[1:0];
    return {s, f, s2, f2, (m_state == 2), (m_state == 1)};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
  endfunction

  // Apply this cycle's effect to the model, then clock and settle past the edge.
  task automatic advance();
    logic [7:0] e;
    e = model_outs();
    if (nRST && m_state == 0) begin
      if (!e[7]) begin
        m_stall  = (m_stall  < 65535) ? m_stall  + 1 : m_stall;
        m_stall2 = (m_stall2 < 3)     ? m_stall2 + 1 : m_stall2;
      end
      if (|e[2:0]) begin
        m_flush  = (m_flush  < 65535) ? m_flush  + 1 : m_flush;
        m_flush2 = (m_flush2 < 3)     ? m_flush2 + 1 : m_flush2;
      end
      if (mwb_halt) m_state = 1;
    end else if (nRST && m_state == 1 && flush_done) begin
      m_state = 2;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b0; ifid_uses_rt = 1'b0; idex_dREN = 1'b0;
    exm_dREN = 1'b0; exm_dWEN = 1'b0; exm_branch_taken = 1'b0; id_jump = 1'b0;
    mwb_halt = 1'b0; flush_done = 1'b0; ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
  endtask

  task automatic test_reset();
    set_idle();
    #3;
    nRST = 1'b0;
    #1;
    model_reset();
    tests++;
    if (outs !== 8'h00) begin
      failed++; $display("FAIL reset_outs got=%b want=%b", outs, 8'h00);
    end
    tests++;
    if (regs !== 38'd0) begin
      failed++; $display("FAIL reset_regs got=%h want=%h", regs, 38'd0);
    end
    @(negedge CLK);
    nRST = 1'b1;
    advance();
    tests++;
    if (regs !== model_regs()) begin
      failed++; $display("FAIL reset_release_regs got=%h want=%h", regs, model_regs());
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 2; c++) begin
      set_idle();
      if (c == 0) begin idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7; end
      #2;
      tests++;
      if (outs !== model_outs()) begin
        failed++; $display("FAIL load_use_outs c=%0d got=%b want=%b", c, outs, model_outs());
      end
      advance();
      tests++;
      if (regs !== model_regs()) begin
        failed++; $display("FAIL load_use_regs c=%0d got=%h want=%h", c, regs, model_regs());
      end
    end
    tests++;
    if (stall_cnt !== 16'd1) begin
      failed++; $display("FAIL load_use_stall got=%0d want=1", stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 4; c++) begin
      set_idle();
      exm_dREN = 1'b1; dhit = (c == 3);
      ihit = $urandom_range(0, 1);
      #2;
      tests++;
      if (outs !== model_outs()) begin
        failed++; $display("FAIL mem_wait_outs c=%0d got=%b want=%b", c, outs, model_outs());
      end
      advance();
      tests++;
      if (regs !== model_regs()) begin
        failed++; $display("FAIL mem_wait_regs c=%0d got=%h want=%h", c, regs, model_regs());
      end
    end
  endtask

  task automatic test_branch_vs_load_use();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      idex_dREN = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9; ifid_uses_rt = 1'b1; ifid_rs = 5'd3;
      exm_branch_taken = (c == 0);
      ihit = (c != 2);
      #2;
      tests++;
      if (outs !== model_outs()) begin
        failed++; $display("FAIL branch_lu_outs c=%0d got=%b want=%b", c, outs, model_outs());
      end
      advance();
      tests++;
      if (regs !== model_regs()) begin
        failed++; $display("FAIL branch_lu_regs c=%0d got=%h want=%h", c, regs, model_regs());
      end
    end
  endtask

  task automatic test_rt_zero();
    set_idle();
    idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b1;
    #2;
    tests++;
    if (outs !== 8'b11111_000) begin
      failed++; $display("FAIL rt_zero_outs got=%b want=%b", outs, 8'b11111_000);
    end
    advance();
    tests++;
    if (regs !== model_regs()) begin
      failed++; $display("FAIL rt_zero_regs got=%h want=%h", regs, model_regs());
    end
  endtask

  task automatic test_saturation();
    test_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      ihit = 1'b0;
      #2;
      tests++;
      if (outs2 !== model_outs()) begin
        failed++; $display("FAIL sat_outs c=%0d got=%b want=%b", c, outs2, model_outs());
      end
      advance();
      tests++;
      if (regs !== model_regs()) begin
        failed++; $display("FAIL sat_regs c=%0d got=%h want=%h", c, regs, model_regs());
      end
    end
    tests++;
    if (stall_cnt2 !== 2'd3 || stall_cnt !== 16'd5) begin
      failed++; $display("FAIL sat_final got=%0d/%0d want=3/5", stall_cnt2, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ihit = ($urandom_range(0, 3) != 0);
      dhit = $urandom_range(0, 1);
      ifid_rs = 5'($urandom_range(0, 3));
      ifid_rt = 5'($urandom_range(0, 3));
      idex_rt = 5'($urandom_range(0, 3));
      ifid_uses_rt = $urandom_range(0, 1);
      idex_dREN = $urandom_range(0, 1);
      exm_dREN = ($urandom_range(0, 3) == 0);
      exm_dWEN = ($urandom_range(0, 5) == 0);
      exm_branch_taken = ($urandom_range(0, 5) == 0);
      id_jump = ($urandom_range(0, 4) == 0);
      mwb_halt = 1'b0;
      flush_done = $urandom_range(0, 1);
      #2;
      tests++;
      if (outs !== model_outs() || outs2 !== outs) begin
        failed++; $display("FAIL random_outs c=%0d got=%b/%b want=%b", c, outs, outs2, model_outs());
      end
      advance();
      tests++;
      if (regs !== model_regs()) begin
        failed++; $display("FAIL random_regs c=%0d got=%h want=%h", c, regs, model_regs());
      end
    end
  endtask

  task automatic test_halt();
    for (int c = 0; c < 9; c++) begin
      set_idle();
      if (c == 0) begin mwb_halt = 1'b1; exm_dREN = 1'b1; dhit = 1'b0; end
      flush_done = (c == 4) || (c > 5 && $urandom_range(0, 1) == 1);
      ihit = c[0];
      if (c > 5) mwb_halt = $urandom_range(0, 1);
      #2;
      tests++;
      if (outs !== model_outs()) begin
        failed++; $display("FAIL halt_outs c=%0d got=%b want=%b", c, outs, model_outs());
      end
      advance();
      tests++;
      if (regs !== model_regs()) begin
        failed++; $display("FAIL halt_regs c=%0d got=%h want=%h", c, regs, model_regs());
      end
    end
    tests++;
    if (halt !== 1'b1 || dcache_flush_req !== 1'b0) begin
      failed++; $display("FAIL halt_sticky got=%b%b want=10", halt, dcache_flush_req);
    end
  endtask

  task automatic test_reset_mid_flush();
    test_reset();
    set_idle();
    mwb_halt = 1'b1; flush_done = 1'b1;
    #2;
    tests++;
    if (outs !== model_outs()) begin
      failed++; $display("FAIL midflush_entry_outs got=%b want=%b", outs, model_outs());
    end
    advance();
    tests++;
    if (regs !== model_regs()) begin
      failed++; $display("FAIL midflush_entry_regs got=%h want=%h", regs, model_regs());
    end
    mwb_halt = 1'b0; flush_done = 1'b0;
    #3;
    nRST = 1'b0;
    #1;
    model_reset();
    tests++;
    if (regs !== 38'd0 || outs !== 8'h00) begin
      failed++; $display("FAIL midflush_reset got=%h/%b want=0/0", regs, outs);
    end
    @(negedge CLK);
    nRST = 1'b1;
    #2;
    tests++;
    if (outs !== model_outs()) begin
      failed++; $display("FAIL midflush_release_outs got=%b want=%b", outs, model_outs());
    end
    advance();
  endtask

  initial begin
    nRST = 1'b1;
    set_idle();
    model_reset();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_vs_load_use();
    test_rt_zero();
    test_saturation();
    test_random();
    test_halt();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
